// File: rtl/control_registros.sv
// rtl/control_registros.sv - MicroUAZ fetch/decode sequencer driving Registros, the write mux and data memory
module control_registros #(
    parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_Instr,
    input  logic        i_Instr_Valid,
    output logic        o_Instr_Ready,
    input  logic        i_Run,
    input  logic        i_Mem_Ack,
    output logic [2:0]  Sel_RX,
    output logic [2:0]  Sel_RY,
    output logic        Load_Store,
    output logic [1:0]  o_Sel_Mux,
    output logic [2:0]  o_Alu_Op,
    output logic [7:0]  o_Imm,
    output logic        o_Mem_Rd,
    output logic        o_Mem_Wr,
    output logic [7:0]  o_PC,
    output logic        o_Busy,
    output logic        o_Illegal,
    output logic        o_Mem_Timeout
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_MEM,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  sel_rx_q, sel_rx_d;
    logic [2:0]  sel_ry_q, sel_ry_d;
    logic [1:0]  sel_mux_q, sel_mux_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  imm_q, imm_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  op;

    assign op = instr_q[15:12];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_FETCH;
            instr_q     <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
            sel_rx_q    <= '0;
            sel_ry_q    <= '0;
            sel_mux_q   <= '0;
            alu_op_q    <= '0;
            imm_q       <= '0;
            wr_strobe_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            sel_rx_q    <= sel_rx_d;
            sel_ry_q    <= sel_ry_d;
            sel_mux_q   <= sel_mux_d;
            alu_op_q    <= alu_op_d;
            imm_q       <= imm_d;
            wr_strobe_q <= wr_strobe_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        sel_rx_d    = sel_rx_q;
        sel_ry_d    = sel_ry_q;
        sel_mux_d   = sel_mux_q;
        alu_op_d    = alu_op_q;
        imm_d       = imm_q;
        wr_strobe_d = 1'b0;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (i_Instr_Valid) begin
                    instr_d = i_Instr;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sel_rx_d  = instr_q[11:9];
                sel_ry_d  = instr_q[8:6];
                alu_op_d  = instr_q[2:0];
                imm_d     = instr_q[7:0];
                sel_mux_d = 2'd0;
                cnt_d     = '0;
                case (op)
                    4'd0: state_d = S_FETCH;
                    4'd1: begin
                        sel_mux_d   = 2'd1;
                        wr_strobe_d = 1'b1;
                        state_d     = S_WRITE;
                    end
                    4'd2: begin
                        sel_mux_d   = 2'd3;
                        wr_strobe_d = 1'b1;
                        state_d     = S_WRITE;
                    end
                    4'd3: begin
                        wr_strobe_d = 1'b1;
                        state_d     = S_WRITE;
                    end
                    4'd4: begin
                        sel_mux_d = 2'd2;
                        mem_rd_d  = 1'b1;
                        state_d   = S_MEM;
                    end
                    4'd5: begin
                        mem_wr_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    4'd6: begin
                        pc_d    = instr_q[7:0];
                        state_d = S_FETCH;
                    end
                    4'd7: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_WRITE: state_d = S_FETCH;
            S_MEM: begin
                // An ack in the limit cycle still wins over the abort.
                if (i_Mem_Ack) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_FETCH;
                end else if (cnt_q + 4'd1 == MEM_TIMEOUT) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HALT: begin
                if (i_Run) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // A load writes back in the very cycle memory data is presented with its ack.
    assign Load_Store    = wr_strobe_q | ((state_q == S_MEM) & mem_rd_q & i_Mem_Ack);
    assign o_Instr_Ready = (state_q == S_FETCH);
    assign o_Busy        = (state_q != S_FETCH) && (state_q != S_HALT);
    assign Sel_RX        = sel_rx_q;
    assign Sel_RY        = sel_ry_q;
    assign o_Sel_Mux     = sel_mux_q;
    assign o_Alu_Op      = alu_op_q;
    assign o_Imm         = imm_q;
    assign o_Mem_Rd      = mem_rd_q;
    assign o_Mem_Wr      = mem_wr_q;
    assign o_PC          = pc_q;
    assign o_Illegal     = illegal_q;
    assign o_Mem_Timeout = timeout_q;

endmodule

// File: tb/tb_control_registros.sv
// tb/tb_control_registros.sv - self-checking bench for control_registros
module tb_control_registros;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [15:0] i_Instr;
    logic        i_Instr_Valid;
    logic        o_Instr_Ready;
    logic        i_Run;
    logic        i_Mem_Ack;
    logic [2:0]  Sel_RX, Sel_RY, o_Alu_Op;
    logic        Load_Store;
    logic [1:0]  o_Sel_Mux;
    logic [7:0]  o_Imm, o_PC;
    logic        o_Mem_Rd, o_Mem_Wr, o_Busy, o_Illegal, o_Mem_Timeout;

    control_registros #(.MEM_TIMEOUT(4'd15)) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Instr(i_Instr), .i_Instr_Valid(i_Instr_Valid),
        .o_Instr_Ready(o_Instr_Ready), .i_Run(i_Run), .i_Mem_Ack(i_Mem_Ack),
        .Sel_RX(Sel_RX), .Sel_RY(Sel_RY), .Load_Store(Load_Store), .o_Sel_Mux(o_Sel_Mux),
        .o_Alu_Op(o_Alu_Op), .o_Imm(o_Imm), .o_Mem_Rd(o_Mem_Rd), .o_Mem_Wr(o_Mem_Wr),
        .o_PC(o_PC), .o_Busy(o_Busy), .o_Illegal(o_Illegal), .o_Mem_Timeout(o_Mem_Timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles; int ls; int rd; int wr; int ill; int tmo; int halt;
        int rx; int ry; int mux; int mchk; int alu; int imm; int pc;
    } res_t;

    typedef struct {
        logic [15:0] ins;
        int          ad;
        int          h;
        res_t        e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mpc;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Expected outcome of one instruction from the architectural rules alone.
    function automatic res_t model(input logic [15:0] ins, input int ad, input int h,
                                   input logic [7:0] pc_before);
        res_t r;
        int   k;
        bit   acked;
        r = '{default: 0};
        r.rx  = int'(ins[11:9]);
        r.ry  = int'(ins[8:6]);
        r.alu = int'(ins[2:0]);
        r.imm = int'(ins[7:0]);
        r.pc  = int'(8'(pc_before + 8'd1));
        case (int'(ins[15:12]))
            1, 2, 3: begin
                r.cycles = 3; r.ls = 1; r.mchk = 1;
                r.mux = (ins[15:12] == 4'd1) ? 1 : (ins[15:12] == 4'd2) ? 3 : 0;
            end
            4, 5: begin
                acked = (ad >= 1) && (ad <= 15);
                k = acked ? ad : 15;
                r.cycles = 2 + k;
                r.tmo = acked ? 0 : 1;
                if (ins[15:12] == 4'd4) begin
                    r.rd = k; r.ls = acked ? 1 : 0; r.mux = 2; r.mchk = 1;
                end else begin
                    r.wr = k;
                end
            end
            6: begin r.cycles = 2; r.pc = int'(ins[7:0]); end
            7: begin r.cycles = 3 + h; r.halt = h + 1; end
            0: r.cycles = 2;
            default: begin r.cycles = 2; r.ill = 1; end
        endcase
        return r;
    endfunction

    // Issue one instruction from FETCH and observe it until the sequencer is ready again.
    task automatic exec(input logic [15:0] ins, input int ad, input int h, output res_t r);
        int cyc, mem_k, halt_k;
        bit done;
        r = '{default: 0};
        i_Instr = ins;
        i_Instr_Valid = 1'b1;
        @(posedge clk); #1;
        cyc = 1; mem_k = 0; halt_k = 0; done = 0;
        while (!done) begin
            if (o_Mem_Rd || o_Mem_Wr) begin
                mem_k++;
                i_Mem_Ack = (mem_k == ad);
            end else begin
                i_Mem_Ack = 1'($urandom);
            end
            if (!o_Instr_Ready && !o_Busy) begin
                halt_k++;
                i_Run = (halt_k == h + 1);
            end else begin
                i_Run = 1'($urandom);
            end
            i_Instr_Valid = o_Instr_Ready ? 1'b0 : 1'($urandom);
            i_Instr = 16'($urandom);
            #1;
            if (Load_Store) r.ls++;
            if (o_Mem_Rd) r.rd++;
            if (o_Mem_Wr) r.wr++;
            if (o_Illegal) r.ill++;
            if (o_Mem_Timeout) r.tmo++;
            if (!o_Instr_Ready && !o_Busy) r.halt++;
            if (o_Mem_Rd && o_Mem_Wr) begin
                n_vec++; n_err++;
                $display("FAIL strobe_overlap: got rd=1 wr=1, expected at most one");
            end
            if (o_Instr_Ready) begin
                done = 1;
                r.cycles = cyc;
                r.rx = int'(Sel_RX); r.ry = int'(Sel_RY); r.mux = int'(o_Sel_Mux);
                r.alu = int'(o_Alu_Op); r.imm = int'(o_Imm); r.pc = int'(o_PC);
            end else if (cyc >= 60) begin
                n_vec++; n_err++;
                $display("FAIL cycle_bound: got %0d cycles without ready, expected return to fetch", cyc);
                done = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        i_Mem_Ack = 1'b0;
        i_Run = 1'b0;
    endtask

    task automatic cmp(input string t, input res_t g, input res_t e);
        chk({t, ".cycles"}, g.cycles, e.cycles);
        chk({t, ".load_store"}, g.ls, e.ls);
        chk({t, ".mem_rd"}, g.rd, e.rd);
        chk({t, ".mem_wr"}, g.wr, e.wr);
        chk({t, ".illegal"}, g.ill, e.ill);
        chk({t, ".timeout"}, g.tmo, e.tmo);
        chk({t, ".halt"}, g.halt, e.halt);
        chk({t, ".sel_rx"}, g.rx, e.rx);
        chk({t, ".sel_ry"}, g.ry, e.ry);
        chk({t, ".alu_op"}, g.alu, e.alu);
        chk({t, ".imm"}, g.imm, e.imm);
        chk({t, ".pc"}, g.pc, e.pc);
        if (e.mchk != 0) chk({t, ".sel_mux"}, g.mux, e.mux);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        i_Instr = 16'h165A;
        i_Instr_Valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_Instr_Valid = 1'b0;
        i_Reset = 1'b0;
        mpc = 8'h00;
    endtask

    vec_t tbl[13];
    res_t got;
    res_t exp_r;

    initial begin
        //                ins       ad  h   cyc ls rd wr il to ht rx ry mx mc alu imm   pc
        tbl[0]  = '{16'h165A, 0,  0, '{3,  1, 0, 0, 0, 0, 0, 3, 1, 1, 1, 2, 'h5A, 'h01}};
        tbl[1]  = '{16'h35C5, 0,  0, '{3,  1, 0, 0, 0, 0, 0, 2, 7, 0, 1, 5, 'hC5, 'h02}};
        tbl[2]  = '{16'h4300, 4,  0, '{6,  1, 4, 0, 0, 0, 0, 1, 4, 2, 1, 0, 'h00, 'h03}};
        tbl[3]  = '{16'h5C00, 0,  0, '{17, 0, 0, 15, 0, 1, 0, 6, 0, 0, 0, 0, 'h00, 'h04}};
        tbl[4]  = '{16'h60FF, 0,  0, '{2,  0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 7, 'hFF, 'hFF}};
        tbl[5]  = '{16'h0000, 0,  0, '{2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h00}};
        tbl[6]  = '{16'h6080, 0,  0, '{2,  0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 'h80, 'h80}};
        tbl[7]  = '{16'h9123, 0,  0, '{2,  0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 3, 'h23, 'h81}};
        tbl[8]  = '{16'h7000, 0,  3, '{6,  0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 'h00, 'h82}};
        tbl[9]  = '{16'h4E40, 1,  0, '{3,  1, 1, 0, 0, 0, 0, 7, 1, 2, 1, 0, 'h40, 'h83}};
        tbl[10] = '{16'h4000, 15, 0, '{17, 1, 15, 0, 0, 0, 0, 0, 0, 2, 1, 0, 'h00, 'h84}};
        tbl[11] = '{16'h2A80, 0,  0, '{3,  1, 0, 0, 0, 0, 0, 5, 2, 3, 1, 0, 'h80, 'h85}};
        tbl[12] = '{16'h5240, 2,  0, '{4,  0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 'h40, 'h86}};

        i_Run = 1'b0;
        i_Mem_Ack = 1'b0;
        do_reset();

        // Reset state, including a valid instruction offered while reset was held.
        chk("rst.pc", int'(o_PC), 0);
        chk("rst.ready", int'(o_Instr_Ready), 1);
        chk("rst.busy", int'(o_Busy), 0);
        chk("rst.load_store", int'(Load_Store), 0);
        chk("rst.sel_rx", int'(Sel_RX), 0);
        chk("rst.imm", int'(o_Imm), 0);
        chk("rst.mem_rd", int'(o_Mem_Rd), 0);

        foreach (tbl[i]) begin
            exec(tbl[i].ins, tbl[i].ad, tbl[i].h, got);
            cmp($sformatf("tbl%0d", i), got, tbl[i].e);
        end

        // Reset while an LD waits for memory: strobes drop at once, nothing is written.
        i_Instr = 16'h4300;
        i_Instr_Valid = 1'b1;
        @(posedge clk); #1;
        i_Instr_Valid = 1'b0;
        @(posedge clk); #1;
        chk("mid.mem_rd_before", int'(o_Mem_Rd), 1);
        @(posedge clk); #2;
        i_Reset = 1'b1;
        #1;
        i_Mem_Ack = 1'b1;
        #1;
        chk("mid.mem_rd", int'(o_Mem_Rd), 0);
        chk("mid.load_store", int'(Load_Store), 0);
        chk("mid.pc", int'(o_PC), 0);
        chk("mid.busy", int'(o_Busy), 0);
        i_Mem_Ack = 1'b0;
        @(posedge clk); #1;
        i_Reset = 1'b0;
        @(posedge clk); #1;
        chk("mid.ready_after", int'(o_Instr_Ready), 1);
        chk("mid.pc_after", int'(o_PC), 0);
        mpc = 8'h00;

        for (int n = 0; n < 60; n++) begin
            logic [15:0] ins;
            int ad, h;
            ins = 16'($urandom);
            ad = $urandom_range(0, 17);
            h = $urandom_range(0, 3);
            exp_r = model(ins, ad, h, mpc);
            exec(ins, ad, h, got);
            cmp($sformatf("rnd%0d_%04h", n, ins), got, exp_r);
            mpc = 8'(exp_r.pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_registros.md
# control_registros

Multi-cycle sequencer for the MicroUAZ register file (Registros). It fetches 16-bit instructions over a valid/ready handshake and decodes them. It then drives the register file's read selects (Sel_RX/Sel_RY), its write strobe (Load_Store) and the write-source mux select. It also controls data-memory strobes and keeps the 8-bit program counter. It sits between program memory and the Registros/ALU/data-memory datapath.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for i_Mem_Ack before abort (4-bit counter; legal values 1–15).
- i_Clk  in  1  system clock; all state changes on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Instr  in  16  instruction word from program memory.
- i_Instr_Valid  in  1  i_Instr is valid.
- o_Instr_Ready  out  1  sequencer accepts an instruction this cycle.
- i_Run  in  1  leaves HALT.
- i_Mem_Ack  in  1  data memory completed the read or write.
- Sel_RX  out  3  RX read select and write address, to Registros.
- Sel_RY  out  3  RY read select, to Registros.
- Load_Store  out  1  register write strobe, to Registros.
- o_Sel_Mux  out  2  Mux_a_Reg source: 0 = ALU, 1 = immediate, 2 = memory data, 3 = RY.
- o_Alu_Op  out  3  ALU operation code.
- o_Imm  out  8  immediate, fed into the write mux.
- o_Mem_Rd  out  1  data-memory read request, address = RY.
- o_Mem_Wr  out  1  data-memory write request, address = RY, data = RX.
- o_PC  out  8  program counter.
- o_Busy  out  1  high in any state other than FETCH or HALT.
- o_Illegal  out  1  one-cycle pulse on an undefined opcode.
- o_Mem_Timeout  out  1  one-cycle pulse on a memory abort.

## Operation
- Instruction fields: op = [15:12], rx = [11:9], ry = [8:6], alu = [2:0], imm = [7:0].
- Opcodes:
  - 0 NOP.
  - 1 MOVI: rx ← imm.
  - 2 MOV: rx ← ry.
  - 3 ALU: rx ← rx alu ry.
  - 4 LD: rx ← mem[ry].
  - 5 ST: mem[ry] ← rx.
  - 6 JMP: PC ← imm.
  - 7 HALT.
  - 8–15: illegal; executed as NOP with o_Illegal pulsed in DECODE.
- States: FETCH, DECODE, WRITE, MEM, HALT. Reset state is FETCH.
- FETCH:
  - o_Instr_Ready = 1.
  - On i_Instr_Valid, latch i_Instr, set PC ← PC+1 (mod 256, 0xFF wraps to 0x00), go to DECODE.
- DECODE:
  - Drive Sel_RX = rx and Sel_RY = ry from the latched instruction; set o_Sel_Mux, o_Alu_Op, o_Imm.
  - MOVI/MOV/ALU → WRITE.
  - LD/ST → MEM.
  - JMP: PC ← imm (overrides the earlier increment), → FETCH.
  - HALT → HALT.
  - NOP or illegal → FETCH.
- WRITE: Load_Store = 1 for exactly one cycle, → FETCH.
- MEM:
  - Hold o_Mem_Rd (LD) or o_Mem_Wr (ST) high; the wait counter increments each cycle without ack.
  - On i_Mem_Ack: LD asserts Load_Store = 1 with o_Sel_Mux = 2 in that same cycle; ST only drops o_Mem_Wr. Both → FETCH.
  - When the counter reaches MEM_TIMEOUT with no ack: pulse o_Mem_Timeout, drop strobes, no register write, → FETCH.
- HALT: o_Instr_Ready = 0; i_Run = 1 → FETCH. PC holds.
- Sel_RX, Sel_RY, o_Sel_Mux, o_Alu_Op and o_Imm hold their values from DECODE until the next DECODE.
- Load_Store is never high outside WRITE or a MEM ack cycle.
- o_Mem_Rd and o_Mem_Wr are never high together.

## Timing
- Reset values:
  - All registered outputs are 0 and PC = 0x00.
  - The counter and latched instruction are 0; state = FETCH.
  - o_Instr_Ready = 1 (decoded from FETCH), but no acceptance while i_Reset is high.
  - o_Busy = 0.
- Reset asserted mid-instruction aborts immediately: strobes fall asynchronously and nothing is written.
- Latency, counted from the acceptance edge:
  - Register ops (MOVI/MOV/ALU): DECODE in cycle 1, Load_Store in cycle 2, next acceptance possible in cycle 3.
  - JMP/NOP/illegal: next acceptance in cycle 2.
  - LD/ST with ack in the first MEM cycle: 3 cycles total.
  - Each ack-wait cycle adds 1; timeout costs MEM_TIMEOUT + 2 cycles.
- Handshake: transfer occurs only on a cycle with o_Instr_Ready & i_Instr_Valid. i_Instr is sampled on that edge only.
- i_Mem_Ack outside MEM is ignored.
- i_Mem_Ack arriving in the same cycle the counter hits the limit counts as an ack; ack has priority and there is no timeout pulse.
- i_Run outside HALT is ignored.
- Outputs are registered and change only on i_Clk rising edges (apart from asynchronous reset). Exceptions, decoded from state: o_Instr_Ready and o_Busy.

## Test plan
- MOVI: reset, then MOVI r3, 0x5A (0x165A) → DECODE sets Sel_RX = 3, o_Sel_Mux = 1, o_Imm = 0x5A; the next cycle has Load_Store = 1 for 1 cycle; o_PC = 0x01.
- ALU: ALU r2 = r2 op5 r7 (0x35C5) → Sel_RX = 2, Sel_RY = 7, o_Alu_Op = 5, o_Sel_Mux = 0, one Load_Store pulse 2 cycles after acceptance.
- LD with delayed ack: LD r1, [r4] (0x4300) with i_Mem_Ack after 4 cycles → o_Mem_Rd high for 4 cycles; Load_Store and o_Sel_Mux = 2 in the ack cycle; no o_Mem_Timeout.
- ST without ack: ST r6, [r0] (0x5C00), ack never asserted → o_Mem_Wr high for 15 cycles, then one o_Mem_Timeout pulse, Load_Store never high, back to FETCH.
- Control flow: start with PC = 0xFF and issue NOP → PC = 0x00. Then JMP 0x80 (0x6080) → PC = 0x80. Then opcode 0x9 → one o_Illegal pulse. Then HALT → o_Instr_Ready = 0 until i_Run = 1.
- Reset mid-operation: assert i_Reset while in MEM during an LD → o_Mem_Rd and Load_Store go to 0 immediately, PC = 0x00, state = FETCH after release.
